// File: rtl/riscv_multicycle_controller.sv
`default_nettype none
// ============================================================================
// riscv_multicycle_controller : Moore FSM sequencing RV32I over shared mem/ALU
// Revision 1.0
// ============================================================================
module riscv_multicycle_controller #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       imm_src,
  output logic             illegal,
  output logic             mem_fault,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_FAULT    = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Counter holds 0..TIMEOUT-1; the TIMEOUT-th unanswered cycle faults.
  localparam int              TO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next_fsm;
  state_t            w_state_next;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_illegal;
  logic              r_mem_fault;
  logic [CNT_W-1:0]  r_instret;

  logic              w_mem_req;
  logic              w_mem_write;
  logic              w_ir_write;
  logic              w_pc_write;
  logic              w_reg_write;
  logic              w_set_illegal;
  logic              w_to_hit;
  logic              w_retire;

  always_comb begin
    w_next_fsm    = r_state;
    w_mem_req     = 1'b0;
    w_mem_write   = 1'b0;
    adr_src       = 1'b0;
    w_ir_write    = 1'b0;
    w_pc_write    = 1'b0;
    w_reg_write   = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    w_set_illegal = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
        if (mem_ready) w_next_fsm = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: w_next_fsm = S_MEMADR;
          OP_RTYPE:          w_next_fsm = S_EXEC_R;
          OP_ITYPE:          w_next_fsm = S_EXEC_I;
          OP_BRANCH: begin
            if (funct3 == 3'b000 || funct3 == 3'b001) begin
              w_next_fsm = S_BRANCH;
            end else begin
              w_next_fsm    = S_FAULT;
              w_set_illegal = 1'b1;
            end
          end
          OP_JAL:            w_next_fsm = S_JAL;
          OP_JALR:           w_next_fsm = S_JALR;
          OP_LUI:            w_next_fsm = S_LUI;
          default: begin
            w_next_fsm    = S_FAULT;
            w_set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        w_next_fsm = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src   = 1'b1;
        w_mem_req = 1'b1;
        if (mem_ready) w_next_fsm = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        w_reg_write = 1'b1;
        w_next_fsm  = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        if (mem_ready) w_next_fsm = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b10;
        w_next_fsm = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = 2'b10;
        w_next_fsm = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a  = 2'b11;
        alu_src_b  = 2'b01;
        w_next_fsm = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next_fsm  = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        w_pc_write = (funct3 == 3'b000) ? zero :
                     (funct3 == 3'b001) ? ~zero : 1'b0;
        w_next_fsm = S_FETCH;
      end
      S_JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        w_next_fsm = S_JAL;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        w_pc_write = 1'b1;
        w_next_fsm = S_ALUWB;
      end
      S_FAULT:  w_next_fsm = S_FAULT;
      default:  w_next_fsm = S_FAULT;
    endcase
  end

  // A same-cycle mem_ready always wins over the timeout.
  assign w_to_hit     = (TIMEOUT != 0) && w_mem_req && !mem_ready && (r_to_cnt == TO_LAST);
  assign w_state_next = w_to_hit ? S_FAULT : w_next_fsm;
  assign w_retire     = (w_state_next == S_FETCH) && (r_state != S_FETCH) && (r_state != S_FAULT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FETCH;
      r_to_cnt    <= '0;
      r_illegal   <= 1'b0;
      r_mem_fault <= 1'b0;
      r_instret   <= '0;
    end else begin
      r_state <= w_state_next;
      if ((TIMEOUT != 0) && w_mem_req && !mem_ready && !w_to_hit) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end else begin
        r_to_cnt <= '0;
      end
      if (w_set_illegal && !r_mem_fault) r_illegal <= 1'b1;
      if (w_to_hit && !r_illegal)        r_mem_fault <= 1'b1;
      if (w_retire)                      r_instret <= r_instret + 1'b1;
    end
  end

  always_comb begin
    imm_src = 3'b000;
    case (op)
      OP_STORE:  imm_src = 3'b001;
      OP_BRANCH: imm_src = 3'b010;
      OP_JAL:    imm_src = 3'b011;
      OP_LUI:    imm_src = 3'b100;
      default:   imm_src = 3'b000;
    endcase
  end

  // Strobes are held low while reset is asserted so nothing is written mid-abort.
  assign mem_req   = w_mem_req   & rst_n;
  assign mem_write = w_mem_write & rst_n;
  assign ir_write  = w_ir_write  & rst_n;
  assign pc_write  = w_pc_write  & rst_n;
  assign reg_write = w_reg_write & rst_n;
  assign illegal   = r_illegal;
  assign mem_fault = r_mem_fault;
  assign instret   = r_instret;
  assign state_o   = r_state;

endmodule
`default_nettype wire

// File: doc/riscv_multicycle_controller.md
# riscv_multicycle_controller

Multi-cycle control unit for the RV32I core, replacing the single-cycle opcode decoder with a Moore state machine that sequences fetch, decode, execute, memory and writeback over several cycles through one shared memory port and one ALU. It drives datapath mux selects and write strobes from its current state and handshakes with memory via `mem_req`/`mem_ready`. Beyond the single-cycle decoder, it adds:

- bne, jalr and lui support;
- illegal-instruction and memory-timeout fault detection;
- a retired-instruction counter.

## Interface

Parameters:

- CNT_W, 32, width of retired-instruction counter `instret`.
- TIMEOUT, 255, consecutive unanswered `mem_req` cycles before memory fault; 0 disables timeout.

Ports:

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  7  opcode from instruction register.
- funct3  in  3  funct3 from instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes current access this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  access is a store.
- adr_src  out  1  0 = PC, 1 = ALUOut as memory address.
- ir_write  out  1  load instruction register and OldPC.
- pc_write  out  1  load PC from result bus.
- reg_write  out  1  register file write.
- result_src  out  2  00 ALUOut, 01 read data, 10 ALU result.
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1, 11 constant 0.
- alu_src_b  out  2  00 rs2, 01 immediate, 10 constant 4.
- alu_op  out  2  00 add, 01 subtract/compare, 10 funct-decoded.
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- illegal  out  1  sticky: unsupported opcode or funct3 decoded.
- mem_fault  out  1  sticky: memory timeout.
- instret  out  CNT_W  retired-instruction count.
- state_o  out  4  current state encoding, for debug.

## Operation

- State encodings:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5;
  - EXEC_R = 6, EXEC_I = 7, ALUWB = 8, BRANCH = 9, JAL = 10, JALR = 11;
  - LUI = 12, FAULT = 15.
- All outputs are combinational from state, plus `mem_ready`/`zero` where noted.
- Unlisted fields in each state are 0.
- `imm_src` decodes from `op` in every state:
  - I for lw, I-ALU and jalr; S for sw; B for branch; J for jal; U for lui; 000 otherwise.
- FETCH:
  - outputs: mem_req=1, a=00, b=10, result_src=10, alu_op=00;
  - ir_write=pc_write=mem_ready;
  - next: DECODE on mem_ready, else hold.
- DECODE:
  - outputs: a=01, b=01, alu_op=00 (branch/jal target into ALUOut);
  - next by op: 0000011/0100011 → MEMADR; 0110011 → EXEC_R; 0010011 → EXEC_I;
  - 1100011 with funct3 000 or 001 → BRANCH; 1101111 → JAL; 1100111 → JALR; 0110111 → LUI;
  - anything else → FAULT, and set illegal.
- MEMADR: a=10, b=01, alu_op=00; next MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: adr_src=1, mem_req=1; next MEMWB on mem_ready.
- MEMWB: result_src=01, reg_write=1; next FETCH.
- MEMWRITE: adr_src=1, mem_req=1, mem_write=1; next FETCH on mem_ready.
- EXEC_R: a=10, b=00, alu_op=10; next ALUWB.
- EXEC_I: a=10, b=01, alu_op=10; next ALUWB.
- LUI: a=11, b=01, alu_op=00; next ALUWB.
- ALUWB: result_src=00, reg_write=1; next FETCH.
- BRANCH:
  - outputs: a=10, b=00, alu_op=01, result_src=00;
  - pc_write = zero when funct3=000, ~zero when funct3=001;
  - next FETCH.
- JALR: a=10, b=01, alu_op=00; next JAL.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1; next ALUWB (writes OldPC+4).
- FAULT:
  - all strobes 0;
  - held until reset.
- instret:
  - increments by 1 on every transition into FETCH from a state other than FETCH or FAULT;
  - wraps modulo 2^CNT_W.
- Timeout counter:
  - counts cycles with mem_req=1 and mem_ready=0; clears on mem_ready or on leaving the memory state;
  - when TIMEOUT≠0 and the count reaches TIMEOUT while still unanswered, next state is FAULT and mem_fault is set;
  - mem_ready in the same cycle takes priority over timeout.

## Timing

- Reset (rst_n=0, asynchronous):
  - state = FETCH; instret = 0; illegal = 0; mem_fault = 0; timeout count = 0;
  - mem_req, ir_write, pc_write, reg_write and mem_write are forced 0 combinationally while rst_n=0.
- First mem_req is asserted in the first cycle after rst_n deasserts.
- Cycles per instruction with zero wait states:
  - R/I-ALU: 4; lw: 5; sw: 4; branch: 3; jal: 4; jalr: 5; lui: 4.
- Each memory wait cycle adds one cycle.
- Reset asserted mid-instruction aborts immediately; no partial writes occur after assertion.
- illegal and mem_fault are mutually exclusive; the first fault to occur wins.

## Test plan

- Reset: hold rst_n=0 with mem_ready=1 → all strobes 0, state_o=0, instret=0; release → mem_req=1 in the next cycle.
- R-type, op=0110011, mem_ready=1 → states 0,1,6,8; reg_write=1 in cycle 4 only; instret=1 at return to FETCH.
- lw with 3 wait cycles in MEMREAD → MEMREAD held 4 cycles; MEMWB with result_src=01; 8 cycles total.
- Branch, op=1100011, funct3=001:
  - zero=0 → pc_write=1 in BRANCH;
  - zero=1 → pc_write=0;
  - funct3=010 → FAULT with illegal=1.
- TIMEOUT=4, mem_ready held 0 in FETCH → FAULT after 4 unanswered cycles; mem_fault=1 stays set until reset.
- CNT_W=4, run 17 lui instructions → instret=1 (wrapped); jalr sequence visits states 0,1,11,10,8.
